led_pattern_gen: RTL and testbench
==================================

# led_pattern_gen

Parametrised multi-channel LED pattern generator driving the board LEDs from a free-running prescaler. It replaces the fixed single-counter blinker with a configurable LED count and tick rate. Pin-driven mode selection picks one of several patterns: binary count, bouncing scan, all-blink, or optional PWM breathe. A hold input freezes the display. The block sits directly between the top-level pins (mode/hold from PMOD inputs) and the LED outputs.

## Interface
- NUM_LEDS, 5: number of LED outputs; legal range 1..32.
- PRESCALE_W, 22: prescaler width; one pattern tick every 2^PRESCALE_W clk cycles; legal range 1..32.
- clk  input  1  system clock; all state is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- MODE  input  2  pattern select; asynchronous pin input, synchronised internally.
- HOLD  input  1  freeze request; asynchronous pin input, synchronised internally.
- LED  output  NUM_LEDS  registered LED drive; bit 0 = LED1.
- TICK  output  1  registered one-cycle pulse on each pattern step.

## Operation
- Reset (reset_n low), all values: prescaler=0, active_mode=0, count=0, pos=0, dir=up, blink=0, duty=0, pwm=0, LED=0, TICK=0, and synchroniser flops=0.
- MODE and HOLD each pass through a 2-flop synchroniser. All rules below use the synchronised values mode_s and hold_s.
- Prescaler: PRESCALE_W-bit up-counter that wraps. It increments every cycle while hold_s=0 and freezes while hold_s=1.
- Internal tick is true when hold_s=0 and the prescaler is all-ones.
- On each tick:
  - If mode_s != active_mode: load active_mode <= mode_s and reinitialise pattern state to reset values (count=0, pos=0, dir=up, blink=0, duty=0). No pattern step occurs on this tick.
  - Otherwise, advance the active pattern one step.
- Mode 0, binary: count (NUM_LEDS bits) += 1 and wraps from all-ones to 0. LED = count.
- Mode 1, scan: LED is one-hot at bit pos.
  - dir=up: if pos==NUM_LEDS-1, set dir=down and pos=NUM_LEDS-2; else pos+=1.
  - dir=down: if pos==0, set dir=up and pos=1; else pos-=1.
  - NUM_LEDS=1: pos stays 0.
  - Ends are not repeated: the sequence for 5 LEDs is 0,1,2,3,4,3,2,1,0,1…
- Mode 2, blink: blink toggles. LED = all bits equal to blink.
- Mode 3, breathe: see Configuration.
- HOLD freezes prescaler, pattern state and pwm, so LED holds its value. Mode changes are deferred until the next tick after release.

## Timing
- TICK and pattern state update on the edge that ends the tick cycle.
- LED reflects the updated state one clk later, i.e. registered from state.
- Pin-to-effect latency: 2 cycles through the synchroniser, then the next tick.
- With HOLD low, steps occur exactly every 2^PRESCALE_W cycles.
- HOLD asserted in the same cycle the prescaler reaches all-ones, after sync: no tick. That tick fires after release.
- Reset asserted mid-pattern: every register returns to its reset value immediately and asynchronously. After reset_n rises, the first tick is at cycle 2^PRESCALE_W.

## Configuration
- LED_BREATHE_EN defined:
  - Mode 3 drives all LEDs with PWM.
  - pwm is an 8-bit free-running counter, incremented each un-held cycle.
  - LED bits = (pwm < duty).
  - Each step, duty ramps 0→255 by 1, then 255→0 by 1, with a direction flag reversing at 255 and at 0. Neither end value is repeated.
  - duty=0 gives LED constant 0.
- LED_BREATHE_EN undefined:
  - No pwm/duty logic is built.
  - Mode 3 behaves exactly like mode 0 (binary), including reinit on entry.

## Test plan
- Reset and binary count (NUM_LEDS=5, PRESCALE_W=2, MODE=0): release reset → LED steps 0,1,2,… every 4 cycles. After 32 steps LED wraps to 0.
- Scan bounce (MODE=1 from reset): after each tick LED = 01h,02h,04h,08h,10h,08h,04h,02h,01h,02h.
- Mode switch mid-count: at count=6, set MODE=2 → at the next tick LED=00h and TICK pulses. The following tick gives LED=1Fh, the next 00h.
- Hold: assert HOLD for 20 cycles at LED=03h → LED stays 03h and no TICK. After release, the next step comes 4 cycles minus the prescaler phase frozen at hold.
- Async reset mid-scan at pos=3 → LED=00h within the same cycle without waiting for a clk edge. After release, the scan restarts at 01h.
- Breathe (LED_BREATHE_EN, MODE=3, PRESCALE_W=1): duty reaches 255, then 254. When duty=64, LED is high for exactly 64 of every 256 cycles. Without the macro, MODE=3 yields binary counting.

Source files
------------

// File: rtl/led_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_pattern_gen: multi-channel LED pattern generator (binary/scan/blink/   |
// | breathe) stepped by a free-running prescaler. LED_BREATHE_EN enables PWM.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module led_pattern_gen #(
  parameter int NUM_LEDS   = 5,
  parameter int PRESCALE_W = 22
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          MODE,
  input  logic                HOLD,
  output logic [NUM_LEDS-1:0] LED,
  output logic                TICK
);

  localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [POS_W-1:0] c_POS_MAX = POS_W'(NUM_LEDS - 1);

  localparam logic [1:0] c_MODE_BINARY  = 2'd0;
  localparam logic [1:0] c_MODE_SCAN    = 2'd1;
  localparam logic [1:0] c_MODE_BLINK   = 2'd2;
  localparam logic [1:0] c_MODE_BREATHE = 2'd3;

  localparam logic c_DIR_UP   = 1'b0;
  localparam logic c_DIR_DOWN = 1'b1;

  logic [1:0]            r_mode_meta, r_mode_s;
  logic                  r_hold_meta, r_hold_s;
  logic [PRESCALE_W-1:0] r_prescaler;
  logic [1:0]            r_active_mode;
  logic [NUM_LEDS-1:0]   r_count;
  logic [POS_W-1:0]      r_pos;
  logic                  r_dir;
  logic                  r_blink;
  logic [NUM_LEDS-1:0]   r_led;
  logic                  r_tick;

  logic                  w_tick;
  logic                  w_mode_change;
  logic [POS_W-1:0]      w_pos_next;
  logic                  w_dir_next;
  logic [NUM_LEDS-1:0]   w_scan;
  logic [NUM_LEDS-1:0]   w_led_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode_meta <= 2'd0;
      r_mode_s    <= 2'd0;
      r_hold_meta <= 1'b0;
      r_hold_s    <= 1'b0;
    end else begin
      r_mode_meta <= MODE;
      r_mode_s    <= r_mode_meta;
      r_hold_meta <= HOLD;
      r_hold_s    <= r_hold_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prescaler <= '0;
    end else if (!r_hold_s) begin
      r_prescaler <= r_prescaler + PRESCALE_W'(1);
    end
  end

  assign w_tick        = ~r_hold_s & (&r_prescaler);
  assign w_mode_change = (r_mode_s != r_active_mode);

  // Bounce without repeating the end positions; a single LED never moves.
  always_comb begin
    w_pos_next = r_pos;
    w_dir_next = r_dir;
    if (NUM_LEDS > 1) begin
      if (r_dir == c_DIR_UP) begin
        if (r_pos == c_POS_MAX) begin
          w_dir_next = c_DIR_DOWN;
          w_pos_next = c_POS_MAX - POS_W'(1);
        end else begin
          w_pos_next = r_pos + POS_W'(1);
        end
      end else begin
        if (r_pos == '0) begin
          w_dir_next = c_DIR_UP;
          w_pos_next = POS_W'(1);
        end else begin
          w_pos_next = r_pos - POS_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active_mode <= c_MODE_BINARY;
      r_count       <= '0;
      r_pos         <= '0;
      r_dir         <= c_DIR_UP;
      r_blink       <= 1'b0;
    end else if (w_tick) begin
      if (w_mode_change) begin
        r_active_mode <= r_mode_s;
        r_count       <= '0;
        r_pos         <= '0;
        r_dir         <= c_DIR_UP;
        r_blink       <= 1'b0;
      end else begin
        case (r_active_mode)
          c_MODE_SCAN: begin
            r_pos <= w_pos_next;
            r_dir <= w_dir_next;
          end
          c_MODE_BLINK: begin
            r_blink <= ~r_blink;
          end
`ifdef LED_BREATHE_EN
          c_MODE_BREATHE: begin
          end
`endif
          default: begin
            r_count <= r_count + NUM_LEDS'(1);
          end
        endcase
      end
    end
  end

`ifdef LED_BREATHE_EN
  logic [7:0] r_pwm;
  logic [7:0] r_duty;
  logic       r_duty_dir;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm      <= 8'd0;
      r_duty     <= 8'd0;
      r_duty_dir <= c_DIR_UP;
    end else begin
      if (!r_hold_s) begin
        r_pwm <= r_pwm + 8'd1;
      end
      if (w_tick) begin
        if (w_mode_change) begin
          r_duty     <= 8'd0;
          r_duty_dir <= c_DIR_UP;
        end else if (r_active_mode == c_MODE_BREATHE) begin
          if (r_duty_dir == c_DIR_UP) begin
            if (r_duty == 8'hFF) begin
              r_duty_dir <= c_DIR_DOWN;
              r_duty     <= 8'hFE;
            end else begin
              r_duty <= r_duty + 8'd1;
            end
          end else begin
            if (r_duty == 8'h00) begin
              r_duty_dir <= c_DIR_UP;
              r_duty     <= 8'h01;
            end else begin
              r_duty <= r_duty - 8'd1;
            end
          end
        end
      end
    end
  end
`endif

  assign w_scan = NUM_LEDS'(1) << r_pos;

  always_comb begin
    w_led_next = r_count;
    case (r_active_mode)
      c_MODE_SCAN:  w_led_next = w_scan;
      c_MODE_BLINK: w_led_next = {NUM_LEDS{r_blink}};
`ifdef LED_BREATHE_EN
      c_MODE_BREATHE: w_led_next = {NUM_LEDS{(r_pwm < r_duty)}};
`endif
      default:      w_led_next = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_led  <= w_led_next;
      r_tick <= w_tick;
    end
  end

  assign LED  = r_led;
  assign TICK = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_led_pattern_gen: directed bench for led_pattern_gen (5 LEDs, 4-cycle    |
// | tick). Revision: 1.0                                                       |
// +----------------------------------------------------------------------------+
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] MODE = 2'd0;
  logic       HOLD = 1'b0;
  logic [4:0] LED;
  logic       TICK;

  int total = 0;
  int bad   = 0;

  logic [4:0] scan_exp [10] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10,
                                5'h08, 5'h04, 5'h02, 5'h01, 5'h02};

  led_pattern_gen #(.NUM_LEDS(5), .PRESCALE_W(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .MODE    (MODE),
    .HOLD    (HOLD),
    .LED     (LED),
    .TICK    (TICK)
  );

  always #5 clk = ~clk;

  // Negedges until TICK is seen high; -1 when the budget runs out.
  task automatic wait_tick(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (TICK === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic apply_reset(input logic [1:0] m);
    reset_n = 1'b0;
    HOLD    = 1'b0;
    MODE    = m;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    MODE = 2'd0;
    HOLD = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (LED !== 5'h00) begin bad++; $display("FAIL reset_led got=%h want=00", LED); end
    total++;
    if (TICK !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", TICK); end
    reset_n = 1'b1;
  endtask

  task automatic test_binary;
    int n;
    logic [4:0] exp;
    for (int k = 0; k < 32; k++) begin
      wait_tick(n);
      total++;
      if (n !== ((k == 0) ? 4 : 3)) begin
        bad++; $display("FAIL binary_period step=%0d got=%0d want=%0d", k, n, (k == 0) ? 4 : 3);
      end
      @(negedge clk);
      exp = 5'(k + 1);
      total++;
      if (LED !== exp) begin bad++; $display("FAIL binary_led step=%0d got=%h want=%h", k, LED, exp); end
    end
  endtask

  task automatic test_mode_switch;
    int n;
    logic [4:0] exp;
    for (int k = 1; k <= 6; k++) begin
      wait_tick(n);
      @(negedge clk);
      exp = 5'(k);
      total++;
      if (LED !== exp) begin bad++; $display("FAIL switch_pre got=%h want=%h", LED, exp); end
    end
    MODE = 2'd2;
    wait_tick(n);
    total++;
    if (n !== 3) begin bad++; $display("FAIL switch_tick got=%0d want=3", n); end
    @(negedge clk);
    total++;
    if (LED !== 5'h00) begin bad++; $display("FAIL switch_entry got=%h want=00", LED); end
    total++;
    if (TICK !== 1'b0) begin bad++; $display("FAIL tick_width got=%b want=0", TICK); end
    wait_tick(n);
    @(negedge clk);
    total++;
    if (LED !== 5'h1F) begin bad++; $display("FAIL blink_on got=%h want=1f", LED); end
    wait_tick(n);
    @(negedge clk);
    total++;
    if (LED !== 5'h00) begin bad++; $display("FAIL blink_off got=%h want=00", LED); end
  endtask

  task automatic test_mode3;
    int n;
    MODE = 2'd3;
    wait_tick(n);
    total++;
    if (n !== 3) begin bad++; $display("FAIL mode3_tick got=%0d want=3", n); end
    @(negedge clk);
    total++;
    if (LED !== 5'h00) begin bad++; $display("FAIL mode3_entry got=%h want=00", LED); end
`ifndef LED_BREATHE_EN
    wait_tick(n);
    @(negedge clk);
    total++;
    if (LED !== 5'h01) begin bad++; $display("FAIL mode3_count1 got=%h want=01", LED); end
    wait_tick(n);
    @(negedge clk);
    total++;
    if (LED !== 5'h02) begin bad++; $display("FAIL mode3_count2 got=%h want=02", LED); end
`endif
  endtask

  task automatic test_hold;
    int n;
    apply_reset(2'd0);
    for (int k = 1; k <= 3; k++) begin
      wait_tick(n);
      @(negedge clk);
    end
    total++;
    if (LED !== 5'h03) begin bad++; $display("FAIL hold_pre got=%h want=03", LED); end
    HOLD = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if (LED !== 5'h03) begin bad++; $display("FAIL hold_led cyc=%0d got=%h want=03", c, LED); end
      total++;
      if (TICK !== 1'b0) begin bad++; $display("FAIL hold_tick cyc=%0d got=%b want=0", c, TICK); end
    end
    HOLD = 1'b0;
    wait_tick(n);
    total++;
    if (n !== 3) begin bad++; $display("FAIL hold_release got=%0d want=3", n); end
    @(negedge clk);
    total++;
    if (LED !== 5'h04) begin bad++; $display("FAIL hold_resume got=%h want=04", LED); end
  endtask

  task automatic test_hold_mode;
    int n;
    HOLD = 1'b1;
    MODE = 2'd2;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (LED !== 5'h04) begin bad++; $display("FAIL holdmode_led cyc=%0d got=%h want=04", c, LED); end
    end
    HOLD = 1'b0;
    wait_tick(n);
    total++;
    if (n !== 3) begin bad++; $display("FAIL holdmode_tick got=%0d want=3", n); end
    @(negedge clk);
    total++;
    if (LED !== 5'h00) begin bad++; $display("FAIL holdmode_entry got=%h want=00", LED); end
    wait_tick(n);
    @(negedge clk);
    total++;
    if (LED !== 5'h1F) begin bad++; $display("FAIL holdmode_blink got=%h want=1f", LED); end
  endtask

  task automatic test_scan;
    int n;
    apply_reset(2'd1);
    for (int k = 0; k < 10; k++) begin
      wait_tick(n);
      total++;
      if (n !== ((k == 0) ? 4 : 3)) begin
        bad++; $display("FAIL scan_period step=%0d got=%0d want=%0d", k, n, (k == 0) ? 4 : 3);
      end
      @(negedge clk);
      total++;
      if (LED !== scan_exp[k]) begin
        bad++; $display("FAIL scan_led step=%0d got=%h want=%h", k, LED, scan_exp[k]);
      end
    end
  endtask

  task automatic test_async_reset;
    int n;
    apply_reset(2'd1);
    for (int k = 0; k < 4; k++) begin
      wait_tick(n);
      @(negedge clk);
    end
    total++;
    if (LED !== 5'h08) begin bad++; $display("FAIL areset_pre got=%h want=08", LED); end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (LED !== 5'h00) begin bad++; $display("FAIL areset_led got=%h want=00", LED); end
    @(negedge clk);
    reset_n = 1'b1;
    wait_tick(n);
    total++;
    if (n !== 4) begin bad++; $display("FAIL areset_first got=%0d want=4", n); end
    @(negedge clk);
    total++;
    if (LED !== 5'h01) begin bad++; $display("FAIL areset_restart got=%h want=01", LED); end
    wait_tick(n);
    @(negedge clk);
    total++;
    if (LED !== 5'h02) begin bad++; $display("FAIL areset_next got=%h want=02", LED); end
  endtask

  initial begin
    test_reset();
    test_binary();
    test_mode_switch();
    test_mode3();
    test_hold();
    test_hold_mode();
    test_scan();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
